// File: rtl/scanchain_pkg.sv
// Shared scan-chain frame geometry and receiver state encoding,
// used by both the scan-chain writer and the receiver.
package scanchain_pkg;

  localparam int ADDR_BITS    = 12;
  localparam int PAYLOAD_BITS = 160;
  localparam int FRAME_BITS   = ADDR_BITS + PAYLOAD_BITS;

  // Counter must hold FRAME_BITS+1 so over-long frames stay distinguishable.
  function automatic int cnt_width(input int frame_bits);
    return $clog2(frame_bits + 2);
  endfunction

  localparam int CNT_BITS = cnt_width(FRAME_BITS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/scan_sync.sv
// Multi-flop synchronizer for one asynchronous scan input, with a history
// flop providing single-cycle rise/fall pulses in the clk domain.
module scan_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Synchronizer chain and edge-detect history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = sync_r[STAGES-1] & ~hist_r;
  assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/scanchain_receiver.sv
// Receives serial scan-chain frames from an asynchronous scan clock domain
// and presents each decoded address/payload/reset-flag on a valid/ready port.
module scanchain_receiver
  import scanchain_pkg::*;
#(
  parameter int ADDR_BITS    = scanchain_pkg::ADDR_BITS,
  parameter int PAYLOAD_BITS = scanchain_pkg::PAYLOAD_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    scan_reset,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [ADDR_BITS-1:0]    rx_addr,
  output logic [PAYLOAD_BITS-1:0] rx_payload,
  output logic                    rx_reset,
  output logic                    frame_error,
  output logic                    overflow,
  output logic                    busy
);

  localparam int FRAME_BITS = ADDR_BITS + PAYLOAD_BITS;
  localparam int CNT_BITS   = cnt_width(FRAME_BITS);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FRAME_BITS);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(FRAME_BITS + 1);

  logic sclk_rise_s, en_level_s, en_rise_s, en_fall_s, din_level_s, srst_level_s;

  scan_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .async_in(scan_clk),
    .level(), .rise(sclk_rise_s), .fall()
  );
  scan_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(clk), .reset(reset), .async_in(scan_en),
    .level(en_level_s), .rise(en_rise_s), .fall(en_fall_s)
  );
  scan_sync #(.STAGES(SYNC_STAGES)) u_sync_in (
    .clk(clk), .reset(reset), .async_in(scan_in),
    .level(din_level_s), .rise(), .fall()
  );
  scan_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk(clk), .reset(reset), .async_in(scan_reset),
    .level(srst_level_s), .rise(), .fall()
  );

  rx_state_t               state_r, next_state_s;
  logic [CNT_BITS-1:0]     cnt_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic                    frame_rst_r;
  logic [SYNC_STAGES:0]    flush_r;
  logic                    armed_r;
  logic                    start_s, load_s, err_s, ovf_s;
  logic                    rx_valid_r, rx_reset_r, frame_error_r, overflow_r, busy_r;
  logic [ADDR_BITS-1:0]    rx_addr_r;
  logic [PAYLOAD_BITS-1:0] rx_payload_r;

  // After reset the synchronizers refill from the pins; a still-high scan_en
  // would look like a fresh rising edge, so frames are only accepted once
  // scan_en has been seen low with the chain flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_r <= {(SYNC_STAGES+1){1'b0}};
      armed_r <= 1'b0;
    end else begin
      flush_r <= {flush_r[SYNC_STAGES-1:0], 1'b1};
      if (flush_r[SYNC_STAGES] && !en_level_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_rise_s && armed_r) next_state_s = ST_SHIFT;
        else                      next_state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (en_fall_s) next_state_s = ST_IDLE;
        else           next_state_s = ST_SHIFT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: frame start and end-of-frame disposition.
  always_comb begin
    start_s = 1'b0;
    load_s  = 1'b0;
    err_s   = 1'b0;
    ovf_s   = 1'b0;
    case (state_r)
      ST_IDLE: start_s = en_rise_s && armed_r;
      ST_SHIFT: begin
        if (en_fall_s) begin
          load_s = (cnt_r == CNT_FULL) && (!rx_valid_r || rx_ready);
          ovf_s  = (cnt_r == CNT_FULL) && rx_valid_r && !rx_ready;
          err_s  = (cnt_r != CNT_FULL);
        end else begin
          load_s = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  // Bit counter, shift register and sticky reset-write flag.
  always_ff @(posedge clk) begin
    if (reset || start_s) begin
      cnt_r       <= {CNT_BITS{1'b0}};
      shift_r     <= {FRAME_BITS{1'b0}};
      frame_rst_r <= 1'b0;
    end else if (state_r == ST_SHIFT && sclk_rise_s && en_level_s) begin
      if (cnt_r != CNT_SAT) cnt_r <= cnt_r + CNT_BITS'(1);
      if (cnt_r < CNT_FULL) shift_r <= {shift_r[FRAME_BITS-2:0], din_level_s};
      if (srst_level_s) frame_rst_r <= 1'b1;
    end
  end

  // Registered output port; a new load takes priority over an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_r    <= 1'b0;
      rx_addr_r     <= {ADDR_BITS{1'b0}};
      rx_payload_r  <= {PAYLOAD_BITS{1'b0}};
      rx_reset_r    <= 1'b0;
      frame_error_r <= 1'b0;
      overflow_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_error_r <= err_s;
      overflow_r    <= ovf_s;
      busy_r        <= (next_state_s == ST_SHIFT);
      if (load_s) begin
        rx_valid_r   <= 1'b1;
        rx_addr_r    <= shift_r[FRAME_BITS-1 -: ADDR_BITS];
        rx_payload_r <= shift_r[PAYLOAD_BITS-1:0];
        rx_reset_r   <= frame_rst_r;
      end else if (rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign rx_valid    = rx_valid_r;
  assign rx_addr     = rx_addr_r;
  assign rx_payload  = rx_payload_r;
  assign rx_reset    = rx_reset_r;
  assign frame_error = frame_error_r;
  assign overflow    = overflow_r;
  assign busy        = busy_r;

endmodule

// File: doc/scanchain_receiver.md
SCANCHAIN_RECEIVER -- requirements
Module: scanchain_receiver

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, frame address width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 160, frame payload width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on scan inputs (minimum 2).
REQ-004 SHALL have port clk  input  1  system clock, frequency at least 10x scan_clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port scan_clk  input  1  asynchronous scan clock, idle low.
REQ-007 SHALL have port scan_en  input  1  asynchronous frame enable.
REQ-008 SHALL have port scan_in  input  1  asynchronous serial data.
REQ-009 SHALL have port scan_reset  input  1  asynchronous reset-write flag.
REQ-010 SHALL have port rx_valid  output  1  decoded frame available.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts frame.
REQ-012 SHALL have port rx_addr  output  ADDR_BITS  decoded address.
REQ-013 SHALL have port rx_payload  output  PAYLOAD_BITS  decoded payload.
REQ-014 SHALL have port rx_reset  output  1  decoded reset-write flag.
REQ-015 SHALL have port frame_error  output  1  one-clk pulse on wrong bit count.
REQ-016 SHALL have port overflow  output  1  one-clk pulse on frame dropped while rx_valid held.
REQ-017 SHALL have port busy  output  1  high while in SHIFT.

Function
REQ-018 SHALL pass scan_clk, scan_en, scan_in and scan_reset each through a SYNC_STAGES flop synchronizer, plus one history flop for edge detection.
REQ-019 SHALL sample synchronized scan_in and scan_reset only on a synchronized scan_clk rising edge while synchronized scan_en is high.
REQ-020 SHALL decode bit order as: first FRAME_BITS = ADDR_BITS+PAYLOAD_BITS sampled bits are address MSB..LSB, then payload MSB..LSB.
REQ-021 SHALL implement states IDLE and SHIFT: IDLE->SHIFT on synchronized scan_en rising; SHIFT->IDLE on synchronized scan_en falling.
REQ-022 SHALL clear the bit counter and shift register on IDLE->SHIFT.
REQ-023 SHALL saturate the bit counter at FRAME_BITS+1; bits beyond FRAME_BITS are discarded.
REQ-024 SHALL set the frame reset flag if scan_reset is sampled high on any sampled edge of the frame.
REQ-025 SHALL, on SHIFT->IDLE with count == FRAME_BITS and rx_valid low or rx_ready high, load rx_addr/rx_payload/rx_reset and assert rx_valid on the next clk edge.
REQ-026 SHALL, on SHIFT->IDLE with count != FRAME_BITS (including 0), pulse frame_error for exactly one clk and leave rx_* unchanged.
REQ-027 SHALL, on SHIFT->IDLE with a good count while rx_valid high and rx_ready low, drop the new frame, pulse overflow for one clk, and hold the old frame.
REQ-028 SHALL deassert rx_valid the clk after rx_valid && rx_ready unless a new frame loads in that cycle (simultaneous load wins, rx_valid stays high).
REQ-029 SHALL hold rx_addr/rx_payload/rx_reset stable while rx_valid high and rx_ready low.
REQ-030 SHALL produce rx_valid at most SYNC_STAGES+3 clks after scan_en falls at the pins.

Reset
REQ-031 SHALL, on reset, force state IDLE, counter 0, rx_valid 0, rx_reset 0, frame_error 0, overflow 0, busy 0, rx_addr 0, rx_payload 0, synchronizers 0.
REQ-032 SHALL abort a frame in progress on reset with no frame_error; a subsequent scan_en falling edge with no rising edge since reset SHALL be ignored.

Structure
REQ-033 SHALL take ADDR_BITS, PAYLOAD_BITS, FRAME_BITS and the counter width ($clog2(FRAME_BITS+2)) from shared package scanchain_pkg, used by writer and receiver alike.
REQ-034 SHALL use one sub-module, scan_sync, per scan input: synchronizer plus rise/fall pulse outputs.

Verification
REQ-035 SHALL cover loopback from the scan-chain writer: addr 0xA5C, payload 0x...DEADBEEF, reset 0 -> one rx_valid with rx_addr 0xA5C, rx_payload matching, rx_reset 0.
REQ-036 SHALL cover reset-write frame: writer reset flag 1, addr 0x001 -> rx_reset 1, rx_addr 0x001.
REQ-037 SHALL cover short (100-bit) and long (180-bit) frames -> one frame_error pulse each, no rx_valid.
REQ-038 SHALL cover back-pressure: rx_ready 0, two good frames (addr 0x010, 0x020) -> overflow pulse once, rx_addr stays 0x010 until accepted.
REQ-039 SHALL cover reset asserted after 50 bits of a frame -> no rx_valid, no frame_error; the next full frame decodes correctly.
REQ-040 SHALL cover simultaneous accept and load: rx_ready pulsed the same cycle a new frame completes -> rx_valid stays high with new data.
